uni_shift_rx: RTL and testbench
===============================

# uni_shift_rx

Serial-in/parallel-out word receiver, the receive end of the universal shift register's serial output. It accepts a framed bitstream, either MSB-first (matching the transmitter's shift-left mode) or LSB-first (matching its shift-right mode), and reassembles N-bit words. Each completed word is presented on a registered valid/ready output port. A sticky overrun flag reports any word lost to backpressure.

## Interface
- N, 8, word width in bits (N ≥ 2)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  frame start; begins a new word and latches msb_first
- msb_first  input  1  sampled only when start=1; 1 = first bit received lands in q[N-1], 0 = first bit lands in q[0]
- sin  input  1  serial data bit
- sin_valid  input  1  sin is valid this cycle
- q  output  N  received word, held stable while q_valid=1
- q_valid  output  1  q holds an unconsumed word
- q_ready  input  1  consumer accepts q this cycle
- busy  output  1  frame in progress
- overrun  output  1  sticky; a completed word was dropped

## Operation
- Internal state:
  - shift register sr[N-1:0]
  - bit counter cnt, width $clog2(N)
  - direction latch dir
  - FSM with states IDLE and RECV
- Reset values:
  - q=0, q_valid=0, busy=0, overrun=0
  - sr=0, cnt=0, FSM=IDLE
- Shift rule, applied on every accepted bit:
  - dir=1: sr ← {sr[N-2:0], sin}
  - dir=0: sr ← {sin, sr[N-1:1]}
- IDLE:
  - sin_valid with start=0 is ignored.
  - start=1: dir ← msb_first, cnt ← 0, go to RECV. If sin_valid=1 in the same cycle, that bit is accepted as bit 0 and cnt ← 1.
- RECV:
  - Each sin_valid=1 cycle shifts one bit in and increments cnt.
  - Cycles with sin_valid=0 hold all state. Gaps of any length are allowed.
- Completion happens on the accepted bit where cnt=N-1:
  - The shifted word is written to q and q_valid is set.
  - cnt ← 0 and the FSM returns to IDLE.
  - A new start is required for every word.
- start=1 while in RECV: the partial word is discarded, dir is relatched, cnt restarts at 0, and the IDLE start rules apply to a same-cycle sin_valid.
- Output handshake:
  - Transfer occurs on any cycle with q_valid=1 and q_ready=1; q_valid then clears next cycle unless a completion lands in that same cycle.
  - Completion while q_valid=0: load q, set q_valid.
  - Completion while q_valid=1 and q_ready=1: load the new word, keep q_valid=1.
  - Completion while q_valid=1 and q_ready=0: drop the new word, keep q unchanged, set overrun.
- overrun is cleared only by reset.
- busy = (FSM == RECV).

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Latency: if the final bit is sampled at edge k, q and q_valid are updated by edge k and are visible during cycle k+1.
- Throughput:
  - With start coinciding with the first bit, back-to-back frames can complete every N cycles.
  - With q_ready held at 1, no word is ever dropped.
- q is stable for as long as q_valid=1 and q_ready=0.
- Asserting reset mid-frame clears everything immediately, without waiting for a clock edge. The next frame after reset deasserts is received correctly.
- Simultaneous events:
  - start together with completion is not possible: start takes precedence and aborts the frame.
  - Transfer together with completion behaves as load, with q_valid staying 1.

## Test plan
- MSB-first: reset, then start=1, msb_first=1 on the first bit. Send 1,0,1,1,0,0,1,0 on 8 consecutive sin_valid cycles, q_ready=1 → q=8'hB2 and q_valid=1 for one cycle, starting the cycle after the 8th bit; busy=1 for bits 2–8.
- LSB-first: same bitstream with msb_first=0 → q=8'h4D.
- Gaps: the MSB-first stream with 0–3 idle cycles (sin_valid=0) inserted randomly between bits → q=8'hB2; no early q_valid.
- Backpressure: q_ready=0. Send MSB-first 8'hAA, then 8'h55 → q stays 8'hAA, q_valid=1, overrun=1. Raise q_ready for one cycle → q_valid drops; overrun stays 1.
- Resync: start, then 3 bits 1,1,1, then start again followed by MSB-first 8'h3C → exactly one q_valid, with q=8'h3C.
- Reset mid-frame: assert reset after 4 bits, between clock edges → q=0, q_valid=0, busy=0, overrun=0 immediately. Release reset, send MSB-first 8'hB2 → q=8'hB2.

Source files
------------

// File: rtl/uni_shift_rx.sv
// Serial-in/parallel-out word receiver: framed MSB- or LSB-first bitstream
// reassembled into N-bit words on a registered valid/ready port.
module uni_shift_rx #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         msb_first,
    input  logic         sin,
    input  logic         sin_valid,
    output logic [N-1:0] q,
    output logic         q_valid,
    input  logic         q_ready,
    output logic         busy,
    output logic         overrun
);

    // state  | meaning
    // S_IDLE | waiting for start, serial bits ignored
    // S_RECV | frame in progress, shifting bits into sr
    typedef enum logic {S_IDLE, S_RECV} state_t;

    localparam int CW = $clog2(N);

    state_t         state, state_nx;
    logic [N-1:0]   sr, sr_nx, sr_shift, q_nx;
    logic [CW-1:0]  cnt, cnt_nx, cnt_eff;
    logic           dir, dir_nx, dir_eff;
    logic           accept, complete;
    logic           q_valid_nx, overrun_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            sr      <= '0;
            cnt     <= '0;
            dir     <= 1'b0;
            q       <= '0;
            q_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nx;
            sr      <= sr_nx;
            cnt     <= cnt_nx;
            dir     <= dir_nx;
            q       <= q_nx;
            q_valid <= q_valid_nx;
            overrun <= overrun_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        sr_nx      = sr;
        cnt_nx     = cnt;
        dir_nx     = dir;
        q_nx       = q;
        q_valid_nx = q_valid;
        overrun_nx = overrun;

        // A start overrides the current frame, so the same-cycle bit uses the new direction.
        dir_eff  = start ? msb_first : dir;
        cnt_eff  = start ? '0 : cnt;
        accept   = sin_valid && (start || (state == S_RECV));
        sr_shift = dir_eff ? {sr[N-2:0], sin} : {sin, sr[N-1:1]};
        complete = accept && (cnt_eff == CW'(N - 1));

        if (start) begin
            state_nx = S_RECV;
            dir_nx   = msb_first;
            cnt_nx   = '0;
        end

        if (accept) begin
            sr_nx = sr_shift;
            if (complete) begin
                cnt_nx   = '0;
                state_nx = S_IDLE;
            end else begin
                cnt_nx = cnt_eff + 1'b1;
            end
        end

        if (q_valid && q_ready)
            q_valid_nx = 1'b0;

        // A word arriving while the held one is still unconsumed is dropped.
        if (complete) begin
            if (!q_valid || q_ready) begin
                q_nx       = sr_shift;
                q_valid_nx = 1'b1;
            end else begin
                overrun_nx = 1'b1;
            end
        end
    end

    assign busy = (state == S_RECV);

endmodule

// File: tb/tb_uni_shift_rx.sv
// Bench for uni_shift_rx: directed vector table, hand-written corner cases,
// and random traffic checked against a bit-queue reference model.
module tb_uni_shift_rx;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset, start, msb_first, sin, sin_valid, q_ready;
    logic [N-1:0] q;
    logic         q_valid, busy, overrun;

    int total = 0;
    int bad   = 0;

    uni_shift_rx #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start), .msb_first(msb_first),
        .sin(sin), .sin_valid(sin_valid), .q(q), .q_valid(q_valid),
        .q_ready(q_ready), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Reference model: received bits kept as a list, word built once N arrive.
    bit           m_bits[$];
    bit           m_active, m_dir, m_qv, m_ovr;
    logic [N-1:0] m_q;

    task automatic model_reset();
        m_bits.delete();
        m_active = 0; m_dir = 0; m_qv = 0; m_ovr = 0; m_q = '0;
    endtask

    task automatic model_edge(input bit st, ms, si, sv, qr);
        logic [N-1:0] w = '0;
        bit done = 0;
        if (st) begin
            m_active = 1; m_dir = ms; m_bits.delete();
        end
        if (m_active && sv) begin
            m_bits.push_back(si);
            if (m_bits.size() == N) begin
                for (int i = 0; i < N; i++) begin
                    if (m_dir) w[N-1-i] = m_bits[i];
                    else       w[i]     = m_bits[i];
                end
                done = 1; m_active = 0; m_bits.delete();
            end
        end
        if (done) begin
            if (!m_qv || qr) begin m_q = w; m_qv = 1; end
            else m_ovr = 1;
        end else if (m_qv && qr) begin
            m_qv = 0;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("model_q", int'(q), int'(m_q));
        chk("model_q_valid", int'(q_valid), int'(m_qv));
        chk("model_busy", int'(busy), int'(m_active));
        chk("model_overrun", int'(overrun), int'(m_ovr));
    endtask

    task automatic step(input bit st, ms, si, sv, qr);
        start = st; msb_first = ms; sin = si; sin_valid = sv; q_ready = qr;
        @(posedge clk);
        #1;
        model_edge(st, ms, si, sv, qr);
        chk_model();
    endtask

    // Start coincides with the first bit; gaps of 0..gapmax idle cycles between bits.
    task automatic send_word(input logic [N-1:0] w, input bit ms, input bit qr, input int gapmax);
        for (int i = 0; i < N; i++) begin
            bit b = ms ? w[N-1-i] : w[i];
            if (i > 0)
                for (int g = $urandom_range(gapmax, 0); g > 0; g--) step(0, 0, 0, 0, qr);
            step(i == 0, ms, b, 1, qr);
        end
    endtask

    task automatic do_reset();
        reset = 1;
        start = 0; msb_first = 0; sin = 0; sin_valid = 0; q_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
    endtask

    typedef struct {
        bit           st, ms, si, sv, qr;
        logic [N-1:0] eq;
        bit           eqv, ebusy, eovr;
    } vec_t;

    vec_t tbl[18];

    initial begin
        logic [7:0] pat;
        int qv_count;

        pat = 8'b1011_0010;
        for (int i = 0; i < 8; i++) begin
            tbl[i]   = '{i == 0, 1, pat[7-i], 1, 1, (i == 7) ? 8'hB2 : 8'h00, i == 7, i != 7, 0};
            tbl[9+i] = '{i == 0, 0, pat[7-i], 1, 1, (i == 7) ? 8'h4D : 8'hB2, i == 7, i != 7, 0};
        end
        tbl[8]  = '{0, 0, 0, 0, 1, 8'hB2, 0, 0, 0};
        tbl[17] = '{0, 0, 0, 0, 1, 8'h4D, 0, 0, 0};

        reset = 1;
        start = 0; msb_first = 0; sin = 0; sin_valid = 0; q_ready = 0;
        model_reset();
        #12;
        chk("reset_q", int'(q), 0);
        chk("reset_q_valid", int'(q_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_overrun", int'(overrun), 0);
        do_reset();

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].st, tbl[i].ms, tbl[i].si, tbl[i].sv, tbl[i].qr);
            chk($sformatf("vec%0d_q", i), int'(q), int'(tbl[i].eq));
            chk($sformatf("vec%0d_q_valid", i), int'(q_valid), int'(tbl[i].eqv));
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].ebusy));
            chk($sformatf("vec%0d_overrun", i), int'(overrun), int'(tbl[i].eovr));
        end

        // Gaps between bits must not produce an early q_valid.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) begin
                if (i > 0)
                    for (int g = $urandom_range(3, 0); g > 0; g--) begin
                        step(0, 0, 0, 0, 1);
                        chk("gap_early_q_valid", int'(q_valid), 0);
                    end
                step(i == 0, 1, pat[7-i], 1, 1);
                if (i < N - 1) chk("gap_early_q_valid", int'(q_valid), 0);
            end
            chk("gap_q", int'(q), 8'hB2);
            chk("gap_q_valid", int'(q_valid), 1);
            step(0, 0, 0, 0, 1);
        end

        // Backpressure: second word dropped, overrun sticky.
        send_word(8'hAA, 1, 0, 0);
        chk("bp_first_q", int'(q), 8'hAA);
        send_word(8'h55, 1, 0, 0);
        chk("bp_q_held", int'(q), 8'hAA);
        chk("bp_q_valid", int'(q_valid), 1);
        chk("bp_overrun", int'(overrun), 1);
        step(0, 0, 0, 0, 1);
        chk("bp_q_valid_drop", int'(q_valid), 0);
        chk("bp_overrun_sticky", int'(overrun), 1);
        step(0, 0, 0, 0, 0);

        // Resync: partial frame abandoned by a new start.
        qv_count = 0;
        step(1, 1, 1, 1, 1); qv_count += int'(q_valid);
        step(0, 0, 1, 1, 1); qv_count += int'(q_valid);
        step(0, 0, 1, 1, 1); qv_count += int'(q_valid);
        for (int i = 0; i < N; i++) begin
            logic [7:0] w = 8'h3C;
            step(i == 0, 1, w[7-i], 1, 1);
            qv_count += int'(q_valid);
            if (i == N - 1) chk("resync_q", int'(q), 8'h3C);
        end
        step(0, 0, 0, 0, 1); qv_count += int'(q_valid);
        step(0, 0, 0, 0, 1); qv_count += int'(q_valid);
        chk("resync_q_valid_count", qv_count, 1);

        // Reset asserted between edges after 4 bits.
        for (int i = 0; i < 4; i++) step(i == 0, 1, pat[7-i], 1, 1);
        #2 reset = 1;
        #1;
        model_reset();
        chk("midrst_q", int'(q), 0);
        chk("midrst_q_valid", int'(q_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_overrun", int'(overrun), 0);
        #1 reset = 0;
        send_word(8'hB2, 1, 1, 0);
        chk("post_rst_q", int'(q), 8'hB2);
        chk("post_rst_q_valid", int'(q_valid), 1);

        // Random traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            bit st = ($urandom_range(11, 0) == 0);
            step(st, 1'($urandom), 1'($urandom), $urandom_range(3, 0) != 0,
                 (c < 300) ? 1'b1 : 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
